// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
package uart_pkg;

    localparam int MIN_DATA_BITS = 5;
    localparam int STATUS_W      = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
        if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
        if (req > max_bits) return max_bits;
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head reads as zero while empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime frame config, feeding a status-tagged FIFO.
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | verifying start bit at its midpoint
// DATA      | sampling data bits LSB first
// PARITY    | sampling and checking the parity bit
// STOP      | sampling one or two stop bits, then pushing the word
// WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  divisor,
    input  logic [3:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    input  logic                  rd_uart,
    input  logic                  clr_overrun,
    output logic [DATA_WIDTH-1:0] R_data,
    output logic [STATUS_W-1:0]   rx_status,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int FW = DATA_WIDTH + STATUS_W;
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    logic                  sync1_q, sync2_q, rxs;
    rx_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d, tcnt_q, tcnt_d;
    logic [SW-1:0]         samp_q, samp_d;
    logic [3:0]            bit_q, bit_d, nbits_q, nbits_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    parity_mode_e          par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d;
    logic                  overrun_q, overrun_d;
    logic                  tick, push, drop;
    logic [FW-1:0]         fifo_rd;

    assign rxs = sync2_q;

    always_comb begin
        tick   = (state_q != IDLE) && (div_q != '0) && (tcnt_q == div_q - DIV_WIDTH'(1));
        tcnt_d = (state_q == IDLE || tick) ? '0 : tcnt_q + DIV_WIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        data_d  = data_q;
        par_d   = par_q;
        stop2_d = stop2_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (!rxs) begin
                state_d = START;
                div_d   = divisor;
                samp_d  = '0;
                bit_d   = '0;
                data_d  = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                nbits_d = clamp_bits(data_bits, 4'(DATA_WIDTH));
                par_d   = parity_mode_e'(parity_mode);
                stop2_d = stop_bits;
            end
            START: if (tick) begin
                if (samp_q == S_MID) begin
                    samp_d  = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    samp_d = samp_q + SW'(1);
                end
            end
            DATA: if (tick) begin
                if (samp_q == S_END) begin
                    samp_d = '0;
                    data_d = data_q | (DATA_WIDTH'(rxs) << bit_q);
                    if (bit_q == nbits_q - 4'(1)) begin
                        bit_d   = '0;
                        state_d = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'(1);
                    end
                end else begin
                    samp_d = samp_q + SW'(1);
                end
            end
            PARITY: if (tick) begin
                if (samp_q == S_END) begin
                    samp_d  = '0;
                    perr_d  = ((^data_q) ^ rxs) != (par_q == PAR_ODD);
                    state_d = STOP;
                end else begin
                    samp_d = samp_q + SW'(1);
                end
            end
            STOP: if (tick) begin
                if (samp_q == S_END) begin
                    samp_d = '0;
                    if (!rxs) ferr_d = 1'b1;
                    if (stop2_q && bit_q == '0) begin
                        bit_d = 4'(1);
                    end else begin
                        push    = 1'b1;
                        state_d = ferr_d ? WAIT_HIGH : IDLE;
                    end
                end else begin
                    samp_d = samp_q + SW'(1);
                end
            end
            WAIT_HIGH: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge UCLK) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            div_q     <= '0;
            tcnt_q    <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            nbits_q   <= 4'(MIN_DATA_BITS);
            data_q    <= '0;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            nbits_q   <= nbits_d;
            data_q    <= data_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (UCLK),
        .reset     (reset),
        .push      (push),
        .push_data ({data_q, perr_q, ferr_d}),
        .pop       (rd_uart),
        .rd_data   (fifo_rd),
        .empty     (rx_empty),
        .full      (rx_full),
        .drop      (drop)
    );

    assign {R_data, rx_status} = fifo_rd;
    assign overrun = overrun_q;

endmodule
